fx_period_counter: RTL and testbench

//  Equal-precision (reciprocal) counting core of the cymometer. Samples the clk_fx

---
 rtl/cymometer_pkg.sv | 19 +
 rtl/fx_edge_sync.sv | 29 ++
 rtl/fx_period_counter.sv | 171 +++++++++++++++++
 tb/tb_fx_period_counter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cymometer_pkg.sv
// Shared definitions for the cymometer counting and display path.
package cymometer_pkg;

    // Default counter width for Nx / Ns and the internal gate counters.
    localparam int unsigned CNT_W_DEF = 32;

    // System clock frequency; the divider/display stage computes
    // f = F_SYS_HZ * Nx / Ns.
    localparam int unsigned F_SYS_HZ = 50_000_000;

    // Measurement controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage : cymometer_pkg

// File: rtl/fx_edge_sync.sv
// Brings the asynchronous signal under test into the sys_clk domain and
// produces a one-cycle pulse for each rising edge.
module fx_edge_sync (
    input  logic sys_clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic meta_q;   // first synchronizer stage, may go metastable
    logic sync_q;   // second synchronizer stage, safe to use
    logic hist_q;   // previous value of sync_q for edge detection

    // Two-flop synchronizer followed by a history flop.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign rise = sync_q & ~hist_q;

endmodule : fx_edge_sync

// File: rtl/fx_period_counter.sv
// Equal-precision (reciprocal) counting core. A gate opens on an fx rising
// edge and closes on the first fx rising edge at or after GATE_CYCLES
// sys_clk cycles; Nx (fx periods) and Ns (sys_clk cycles) inside the gate
// are reported for the downstream divider.
module fx_period_counter
    import cymometer_pkg::*;
#(
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned GATE_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter bit          AUTO_RESTART   = 1'b1
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fx_in,
    output logic             busy,
    output logic [CNT_W-1:0] fx_cnt,
    output logic [CNT_W-1:0] std_cnt,
    output logic             meas_valid,
    output logic             meas_timeout
);

    // Parameter sanity: the abort limit must exceed the gate, and no counter
    // may ever wrap.
    if (TIMEOUT_CYCLES <= GATE_CYCLES) begin : g_bad_timeout_vs_gate
        $error("fx_period_counter: TIMEOUT_CYCLES must exceed GATE_CYCLES");
    end
    if ((TIMEOUT_CYCLES >> CNT_W) != 0) begin : g_bad_timeout_vs_width
        $error("fx_period_counter: TIMEOUT_CYCLES must be below 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] GATE_N = CNT_W'(GATE_CYCLES);
    localparam logic [CNT_W-1:0] TMO_N  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

    logic fx_rise;

    fx_edge_sync u_fx_sync (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .async_in (fx_in),
        .rise     (fx_rise)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;       // cycles spent waiting in ARM
    logic [CNT_W-1:0] std_q, std_d;         // Ns accumulating inside the gate
    logic [CNT_W-1:0] nx_q, nx_d;           // Nx accumulating inside the gate
    logic             abort_q, abort_d;     // measurement ended by timeout
    logic [CNT_W-1:0] fx_cnt_q, fx_cnt_d;
    logic [CNT_W-1:0] std_cnt_q, std_cnt_d;
    logic             valid_q, valid_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] std_inc;

    // State, counters and result registers.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            std_q     <= '0;
            nx_q      <= '0;
            abort_q   <= 1'b0;
            fx_cnt_q  <= '0;
            std_cnt_q <= '0;
            valid_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            std_q     <= std_d;
            nx_q      <= nx_d;
            abort_q   <= abort_d;
            fx_cnt_q  <= fx_cnt_d;
            std_cnt_q <= std_cnt_d;
            valid_q   <= valid_d;
            tmo_q     <= tmo_d;
        end
    end

    // Gate control: next state, counter updates and result latching.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        std_d     = std_q;
        nx_d      = nx_q;
        abort_d   = abort_q;
        fx_cnt_d  = fx_cnt_q;
        std_cnt_d = std_cnt_q;
        valid_d   = 1'b0;
        tmo_d     = tmo_q;
        // Ns including the current cycle, so the closing-edge cycle counts.
        std_inc   = std_q + ONE;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                    wait_d  = '0;
                    std_d   = '0;
                    nx_d    = '0;
                    abort_d = 1'b0;
                end
            end

            ST_ARM: begin
                wait_d = wait_q + ONE;
                if (fx_rise) begin
                    state_d = ST_MEASURE;
                    std_d   = '0;
                    nx_d    = '0;
                end else if (wait_q == TMO_M1) begin
                    state_d = ST_DONE;
                    abort_d = 1'b1;
                end
            end

            ST_MEASURE: begin
                std_d = std_inc;
                if (fx_rise) begin
                    nx_d = nx_q + ONE;
                end
                // A closing edge wins over a timeout in the same cycle.
                if (fx_rise && (std_inc >= GATE_N)) begin
                    state_d = ST_DONE;
                    abort_d = 1'b0;
                end else if (std_inc == TMO_N) begin
                    state_d = ST_DONE;
                    abort_d = 1'b1;
                end
            end

            ST_DONE: begin
                valid_d = 1'b1;
                if (abort_q) begin
                    fx_cnt_d  = '0;
                    std_cnt_d = '0;
                    tmo_d     = 1'b1;
                end else begin
                    fx_cnt_d  = nx_q;
                    std_cnt_d = std_q;
                    tmo_d     = 1'b0;
                end
                // The closing edge has already passed, so a re-armed gate
                // opens on a later fx rising edge.
                if (AUTO_RESTART) begin
                    state_d = ST_ARM;
                    wait_d  = '0;
                    std_d   = '0;
                    nx_d    = '0;
                    abort_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy         = (state_q != ST_IDLE);
    assign fx_cnt       = fx_cnt_q;
    assign std_cnt      = std_cnt_q;
    assign meas_valid   = valid_q;
    assign meas_timeout = tmo_q;

endmodule : fx_period_counter

// File: tb/tb_fx_period_counter.sv
// Directed bench: instance A re-arms automatically, instance B returns to
// IDLE after each result. Both run concurrently from one clock.
module tb_fx_period_counter;

    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic          rst_a, start_a, fx_a, busy_a, valid_a, tmo_a;
    logic [CW-1:0] fxc_a, stdc_a;
    logic          rst_b, start_b, fx_b, busy_b, valid_b, tmo_b;
    logic [CW-1:0] fxc_b, stdc_b;

    logic en_a = 1'b0, en_b = 1'b0;
    int   per_a = 1000, per_b = 1000;
    int   ph_a = 0, ph_b = 0;

    int n_checks = 0;
    int n_errors = 0;

    fx_period_counter #(
        .CNT_W          (CW),
        .GATE_CYCLES    (10_000),
        .TIMEOUT_CYCLES (20_000),
        .AUTO_RESTART   (1'b1)
    ) dut_a (
        .sys_clk      (clk),
        .rst          (rst_a),
        .start        (start_a),
        .fx_in        (fx_a),
        .busy         (busy_a),
        .fx_cnt       (fxc_a),
        .std_cnt      (stdc_a),
        .meas_valid   (valid_a),
        .meas_timeout (tmo_a)
    );

    fx_period_counter #(
        .CNT_W          (CW),
        .GATE_CYCLES    (10_000),
        .TIMEOUT_CYCLES (20_000),
        .AUTO_RESTART   (1'b0)
    ) dut_b (
        .sys_clk      (clk),
        .rst          (rst_b),
        .start        (start_b),
        .fx_in        (fx_b),
        .busy         (busy_b),
        .fx_cnt       (fxc_b),
        .std_cnt      (stdc_b),
        .meas_valid   (valid_b),
        .meas_timeout (tmo_b)
    );

    // fx generators: period in sys_clk cycles, 50% duty, changes on negedge.
    initial begin
        fx_a = 1'b0;
        forever begin
            @(negedge clk);
            if (!en_a) begin
                ph_a = 0;
                fx_a = 1'b0;
            end else begin
                fx_a = (ph_a < per_a / 2);
                ph_a = (ph_a >= per_a - 1) ? 0 : ph_a + 1;
            end
        end
    end

    initial begin
        fx_b = 1'b0;
        forever begin
            @(negedge clk);
            if (!en_b) begin
                ph_b = 0;
                fx_b = 1'b0;
            end else begin
                fx_b = (ph_b < per_b / 2);
                ph_b = (ph_b >= per_b - 1) ? 0 : ph_b + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clk);
        #1;
        if (sel) start_b = 1'b0;
        else     start_a = 1'b0;
    endtask

    // Returns the number of posedges until meas_valid is seen, or -1.
    task automatic wait_valid(input bit sel, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if ((sel ? valid_b : valid_a) == 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; start_a = 1'b0;
        rst_b = 1'b1; start_b = 1'b0;
        fork
            // ---------------- instance A (AUTO_RESTART=1) ----------------
            begin
                int n;
                repeat (3) @(posedge clk);
                #1;
                check("a_rst_busy",  busy_a,  1'b0);
                check("a_rst_fxc",   fxc_a,   0);
                check("a_rst_stdc",  stdc_a,  0);
                check("a_rst_valid", valid_a, 1'b0);
                check("a_rst_tmo",   tmo_a,   1'b0);
                @(negedge clk);
                rst_a = 1'b0;
                per_a = 1000;
                en_a  = 1'b1;
                repeat (20) @(posedge clk);
                #1;

                // fx = sys_clk/1000, then a second back-to-back result
                pulse_start(1'b0);
                wait_valid(1'b0, 15000, n);
                check("t1_seen", n > 0, 1'b1);
                check("t1_fxc",  fxc_a,  10);
                check("t1_stdc", stdc_a, 10000);
                check("t1_tmo",  tmo_a,  1'b0);
                @(posedge clk);
                #1;
                check("t1_pulse_1cyc", valid_a, 1'b0);
                check("t6_rearm_busy", busy_a,  1'b1);
                check("t6_hold_fxc",   fxc_a,   10);
                wait_valid(1'b0, 12000, n);
                check("t6_second_seen", n > 0, 1'b1);
                check("t6_second_fxc",  fxc_a,  10);
                check("t6_second_stdc", stdc_a, 10000);

                // fx period 1500: gate closes at 10500
                @(negedge clk);
                rst_a = 1'b1;
                en_a  = 1'b0;
                per_a = 1500;
                repeat (3) @(posedge clk);
                @(negedge clk);
                rst_a = 1'b0;
                en_a  = 1'b1;
                repeat (20) @(posedge clk);
                #1;
                pulse_start(1'b0);
                wait_valid(1'b0, 16000, n);
                check("t2_seen", n > 0, 1'b1);
                check("t2_fxc",  fxc_a,  7);
                check("t2_stdc", stdc_a, 10500);
                check("t2_tmo",  tmo_a,  1'b0);

                // reset in the middle of the re-armed measurement
                repeat (3000) @(posedge clk);
                #1;
                check("t5_pre_busy", busy_a, 1'b1);
                @(negedge clk);
                rst_a = 1'b1;
                @(posedge clk);
                #1;
                check("t5_busy",  busy_a,  1'b0);
                check("t5_fxc",   fxc_a,   0);
                check("t5_stdc",  stdc_a,  0);
                check("t5_valid", valid_a, 1'b0);
                check("t5_tmo",   tmo_a,   1'b0);
                @(negedge clk);
                rst_a = 1'b0;
                per_a = 1000;
                wait_valid(1'b0, 100, n);
                check("t5_idle_quiet", n < 0, 1'b1);
                check("t5_idle_busy",  busy_a, 1'b0);
                pulse_start(1'b0);
                wait_valid(1'b0, 15000, n);
                check("t5_after_seen", n > 0, 1'b1);
                check("t5_after_fxc",  fxc_a,  10);
                check("t5_after_stdc", stdc_a, 10000);
                check("t5_after_tmo",  tmo_a,  1'b0);
            end

            // ---------------- instance B (AUTO_RESTART=0) ----------------
            begin
                int n;
                repeat (3) @(posedge clk);
                #1;
                check("b_rst_busy", busy_b, 1'b0);
                check("b_rst_fxc",  fxc_b,  0);
                @(negedge clk);
                rst_b = 1'b0;
                per_b = 1000;
                en_b  = 1'b1;
                repeat (20) @(posedge clk);
                #1;

                // single result; a start while busy is ignored
                pulse_start(1'b1);
                repeat (2000) @(posedge clk);
                #1;
                check("t6b_busy_mid", busy_b, 1'b1);
                pulse_start(1'b1);
                wait_valid(1'b1, 15000, n);
                check("t6b_seen", n > 0, 1'b1);
                check("t6b_fxc",  fxc_b,  10);
                check("t6b_stdc", stdc_b, 10000);
                check("t6b_tmo",  tmo_b,  1'b0);
                @(posedge clk);
                #1;
                check("t6b_idle_busy", busy_b, 1'b0);
                wait_valid(1'b1, 3000, n);
                check("t6b_no_extra",  n < 0, 1'b1);
                check("t6b_still_idle", busy_b, 1'b0);
                check("t6b_hold_stdc", stdc_b, 10000);

                // fx held low: abort in ARM, valid 20001 cycles after start
                en_b = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                pulse_start(1'b1);
                wait_valid(1'b1, 21000, n);
                check("t3_latency", n, 20001);
                check("t3_tmo",  tmo_b,  1'b1);
                check("t3_fxc",  fxc_b,  0);
                check("t3_stdc", stdc_b, 0);
                @(posedge clk);
                #1;
                check("t3_pulse_1cyc", valid_b, 1'b0);
                check("t3_busy",       busy_b,  1'b0);

                // one fx pulse only: gate opens, then aborts in MEASURE.
                // Edge lands 5000 cycles after start; gate opens 2 cycles
                // later, abort state reached 20000 cycles after that, and
                // valid one cycle on: 25003 total, 5499 already consumed.
                pulse_start(1'b1);
                repeat (4999) @(posedge clk);
                #1;
                en_b = 1'b1;
                repeat (500) @(posedge clk);
                #1;
                en_b = 1'b0;
                wait_valid(1'b1, 21000, n);
                check("t4_latency", n, 19504);
                check("t4_tmo",  tmo_b,  1'b1);
                check("t4_fxc",  fxc_b,  0);
                check("t4_stdc", stdc_b, 0);
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fx_period_counter
